// File: rtl/counter_arbiter.sv
// counter_arbiter
// ---------------
// Shares one external up/down counter between two requesters. Each requester
// posts a job (start value, direction, step count). Jobs are granted
// round-robin. The granted job is sequenced onto the counter control pins,
// and completion is reported to the owner together with a status and the
// final count.
//
// Optional build macro: COUNTER_ARBITER_WRAP_EN
//   undefined : a step that would cross all-ones (up) or zero (down) stops the
//               job early with status 01 (saturated).
//   defined   : the boundary check is removed and the counter wraps modulo
//               2^N. Status 01 never occurs in this build.
//
// Ports
//   clk, reset             : rising-edge clock, asynchronous active-low reset
//   req0/1                 : job request, held until the matching grant
//   up0/1, start0/1,
//   steps0/1               : job parameters, sampled in the grant cycle
//   kill                   : synchronous abort of the active job (LOAD/RUN only)
//   gnt0/1                 : one-cycle grant pulse
//   done0/1                : one-cycle completion pulse to the job owner
//   status                 : 00 ok, 01 saturated, 10 killed (valid with done)
//   result_q               : final counter value (valid with done, else 0)
//   busy                   : high in LOAD, RUN and DONE
//   cnt_clr/load/en/up,
//   cnt_d                  : controls for the shared counter
//   cnt_max_tick/min_tick,
//   cnt_q                  : counter status and value
//   state_dbg              : current FSM state (IDLE=0 LOAD=1 RUN=2 DONE=3)
//
// Handshake: a request stays high until the grant pulse. The grant is
// combinational in IDLE, so the job parameters must be stable in that cycle.
// done is a Moore pulse in DONE. It is not acknowledged.
module counter_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic         up0,
  input  logic         up1,
  input  logic [N-1:0] start0,
  input  logic [N-1:0] start1,
  input  logic [N-1:0] steps0,
  input  logic [N-1:0] steps1,
  input  logic         kill,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [1:0]   status,
  output logic [N-1:0] result_q,
  output logic         busy,
  output logic         cnt_clr,
  output logic         cnt_load,
  output logic         cnt_en,
  output logic         cnt_up,
  output logic [N-1:0] cnt_d,
  input  logic         cnt_max_tick,
  input  logic         cnt_min_tick,
  input  logic [N-1:0] cnt_q,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_SAT  = 2'b01;
  localparam logic [1:0] ST_KILL = 2'b10;

  state_t       state, state_nxt;
  logic         rr;        // 0: requester 0 wins a tie, 1: requester 1 wins
  logic         owner;
  logic         up_r;
  logic [N-1:0] start_r;
  logic [N-1:0] steps_r;
  logic [N-1:0] rem, rem_nxt;
  logic [1:0]   status_r, status_nxt;
  logic         grant;
  logic         gnt_who;
  logic         at_bound;

`ifdef COUNTER_ARBITER_WRAP_EN
  logic unused_ticks;
  assign unused_ticks = cnt_max_tick ^ cnt_min_tick;
  assign at_bound     = 1'b0;
`else
  // The next step would run past the counter range in the job's direction.
  assign at_bound = up_r ? cnt_max_tick : cnt_min_tick;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr       <= 1'b0;
      owner    <= 1'b0;
      up_r     <= 1'b0;
      start_r  <= '0;
      steps_r  <= '0;
      rem      <= '0;
      status_r <= ST_OK;
    end else begin
      state    <= state_nxt;
      rem      <= rem_nxt;
      status_r <= status_nxt;
      if (grant) begin
        owner   <= gnt_who;
        up_r    <= gnt_who ? up1 : up0;
        start_r <= gnt_who ? start1 : start0;
        steps_r <= gnt_who ? steps1 : steps0;
        rr      <= ~gnt_who;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    status_nxt = status_r;
    grant      = 1'b0;
    gnt_who    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_up     = 1'b0;
    cnt_d      = '0;
    case (state)
      IDLE: begin
        // The grant is gated by reset so that every output stays 0
        // while reset is asserted, even when requests are pending.
        if (reset && (req0 || req1)) begin
          grant      = 1'b1;
          gnt_who    = (req0 && req1) ? rr : req1;
          status_nxt = ST_OK;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        cnt_load = 1'b1;
        cnt_d    = start_r;
        if (kill) begin
          status_nxt = ST_KILL;
          state_nxt  = DONE;
        end else if (steps_r == '0) begin
          state_nxt = DONE;
        end else begin
          rem_nxt   = steps_r;
          state_nxt = RUN;
        end
      end
      RUN: begin
        cnt_up = up_r;
        if (kill) begin
          cnt_clr    = 1'b1;
          status_nxt = ST_KILL;
          state_nxt  = DONE;
        end else if (at_bound) begin
          status_nxt = ST_SAT;
          state_nxt  = DONE;
        end else begin
          cnt_en  = 1'b1;
          rem_nxt = rem - N'(1);
          if (rem == N'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt0      = grant & ~gnt_who;
  assign gnt1      = grant & gnt_who;
  assign done0     = (state == DONE) & ~owner;
  assign done1     = (state == DONE) & owner;
  assign status    = status_r;
  assign result_q  = (state == DONE) ? cnt_q : '0;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter. It includes a behavioural model of the shared
// counter, which sets clr > load > en priority, with ticks decoded from q.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// on the falling edge.
module tb_counter_arbiter;
  localparam int N = 3;
  localparam int W = 1 + 2 + N + 16;  // {owner, status, result, done cycle}

  logic         clk, reset;
  logic         req0, req1, up0, up1, kill;
  logic [N-1:0] start0, start1, steps0, steps1;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [1:0]   status, state_dbg;
  logic [N-1:0] result_q, cnt_d;
  logic         cnt_clr, cnt_load, cnt_en, cnt_up;
  logic         cnt_max_tick, cnt_min_tick;
  logic [N-1:0] cnt_q;

  logic [W-1:0] exp_q[$];
  int           vectors, miscompares;
  int           cyc;

  counter_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .up0(up0), .up1(up1),
    .start0(start0), .start1(start1), .steps0(steps0), .steps1(steps1),
    .kill(kill),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .status(status), .result_q(result_q), .busy(busy),
    .cnt_clr(cnt_clr), .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_up(cnt_up),
    .cnt_d(cnt_d), .cnt_max_tick(cnt_max_tick), .cnt_min_tick(cnt_min_tick),
    .cnt_q(cnt_q), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // shared counter model
  always @(posedge clk or negedge reset) begin
    if (!reset)        cnt_q <= '0;
    else if (cnt_clr)  cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_en)   cnt_q <= cnt_up ? cnt_q + 3'd1 : cnt_q - 3'd1;
  end
  assign cnt_max_tick = &cnt_q;
  assign cnt_min_tick = (cnt_q == '0);

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (done0 || done1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done0=%0b done1=%0b cycle %0d", done0, done1, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_both", int'(done0 && done1), 0);
        chk("done_owner", int'(done1), int'(e[W-1]));
        chk("done_status", int'(status), int'(e[W-2 -: 2]));
        chk("done_result", int'(result_q), int'(e[16 +: N]));
        chk("done_cycle", cyc & 16'hffff, int'(e[15:0]));
      end
    end
  end

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL done_timeout: %0d jobs pending", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // driver: one job, with an optional kill in the given cycle after the grant
  // (0 = LOAD, k>0 = k-th RUN cycle, -1 = none) and the done latency after gnt
  task automatic run_job(input logic who, input logic u, input logic [N-1:0] st,
                         input logic [N-1:0] sp, input int kill_at,
                         input logic [1:0] es, input logic [N-1:0] er, input int lat);
    bit got;
    int t;
    @(posedge clk); #1;
    if (who) begin req1 = 1'b1; up1 = u; start1 = st; steps1 = sp; end
    else     begin req0 = 1'b1; up0 = u; start0 = st; steps0 = sp; end
    got = 0;
    t = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        got = 1;
        t = cyc;
        chk("job_gnt_owner", int'(gnt1), int'(who));
      end
    end
    if (!got) begin
      chk("job_gnt_timeout", 0, 1);
      req0 = 1'b0;
      req1 = 1'b0;
      return;
    end
    exp_q.push_back({who, es, er, 16'(t + lat)});
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    if (kill_at >= 0) begin
      repeat (kill_at) @(posedge clk);
      if (kill_at > 0) #1;
      kill = 1'b1;
      @(negedge clk);
      chk("kill_clr", int'(cnt_clr), int'(kill_at > 0));
      chk("kill_en", int'(cnt_en), 0);
      @(posedge clk); #1;
      kill = 1'b0;
    end
    drain();
  endtask

  initial begin
    bit got;
    int t;
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    kill = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    up0 = 1'b1;  up1 = 1'b1;
    start0 = 3'd1; start1 = 3'd2;
    steps0 = 3'd0; steps1 = 3'd0;

    // reset state, with both requests already pending
    repeat (2) @(negedge clk);
    chk("rst_gnt", int'({gnt0, gnt1}), 0);
    chk("rst_done", int'({done0, done1}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'({cnt_clr, cnt_load, cnt_en, cnt_up}), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_result", int'(result_q), 0);
    chk("rst_state", int'(state_dbg), 0);

    // both requesters held: grants alternate 0,1,0,1
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      t = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (gnt0 || gnt1) begin got = 1; t = cyc; end
      end
      if (!got) begin
        chk("alt_timeout", 0, 1);
        break;
      end
      chk("alt_gnt0", int'(gnt0), int'(k % 2 == 0));
      chk("alt_gnt1", int'(gnt1), int'(k % 2 == 1));
      exp_q.push_back({gnt1, 2'b00, (gnt1 ? 3'd2 : 3'd1), 16'(t + 2)});
      @(posedge clk);
    end
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    drain();

    // directed jobs: who, up, start, steps, kill_at, status, result, latency
    run_job(1'b0, 1'b1, 3'd2, 3'd3, -1, 2'b00, 3'd5, 5);
    run_job(1'b1, 1'b0, 3'd3, 3'd0, -1, 2'b00, 3'd3, 2);
    run_job(1'b0, 1'b1, 3'd1, 3'd5,  2, 2'b10, 3'd0, 4);
    run_job(1'b1, 1'b1, 3'd4, 3'd2,  0, 2'b10, 3'd4, 2);
    run_job(1'b0, 1'b1, 3'd0, 3'd7, -1, 2'b00, 3'd7, 9);
`ifdef COUNTER_ARBITER_WRAP_EN
    run_job(1'b0, 1'b1, 3'd6, 3'd4, -1, 2'b00, 3'd2, 6);
    run_job(1'b1, 1'b0, 3'd1, 3'd3, -1, 2'b00, 3'd6, 5);
    run_job(1'b0, 1'b1, 3'd6, 3'd3, -1, 2'b00, 3'd1, 5);
`else
    run_job(1'b0, 1'b1, 3'd6, 3'd4, -1, 2'b01, 3'd7, 4);
    run_job(1'b1, 1'b0, 3'd1, 3'd3, -1, 2'b01, 3'd0, 4);
    run_job(1'b0, 1'b1, 3'd6, 3'd3, -1, 2'b01, 3'd7, 4);
`endif

    // reset in the middle of RUN: no done, outputs clear immediately
    @(posedge clk); #1;
    req0 = 1'b1; up0 = 1'b1; start0 = 3'd0; steps0 = 3'd7;
    @(negedge clk);
    chk("mid_gnt0", int'(gnt0), 1);
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("mid_pre_en", int'(cnt_en), 1);
    reset = 1'b0;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_cnt", int'({cnt_clr, cnt_load, cnt_en, cnt_up}), 0);
    chk("mid_state", int'(state_dbg), 0);
    chk("mid_out", int'({gnt0, gnt1, done0, done1, status, result_q}), 0);
    repeat (3) @(negedge clk);

    // after release, a tie goes to requester 0
    @(posedge clk); #1;
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    up0 = 1'b1; start0 = 3'd5; steps0 = 3'd0;
    up1 = 1'b1; start1 = 3'd6; steps1 = 3'd0;
    @(negedge clk);
    chk("post_rst_gnt0", int'(gnt0), 1);
    chk("post_rst_gnt1", int'(gnt1), 0);
    exp_q.push_back({1'b0, 2'b00, 3'd5, 16'(cyc + 2)});
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
